// File: rtl/arm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : arm_pkg                                                         |
// | Purpose  : Shared flag-vector type, NZCV bit positions and the             |
// |            status-register FSM state encoding.                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package arm_pkg;

  typedef logic [3:0] flags_t;

  // Bit positions inside a {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_EXC    = 1'b1
  } sr_state_e;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/flag_next_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flag_next_sel                                                   |
// | Purpose  : Combinational CPSR next-value priority mux and the bypass       |
// |            select that feeds the ID-stage condition checker.               |
// | Ports    : cpsr_q, spsr_q    current architectural / saved flags          |
// |            exe_upd, exe_flags  qualified EXE flag update and its value     |
// |            msr_we, msr_mask, msr_data  masked direct write                 |
// |            legal_restore     exception return accepted this cycle         |
// |            freeze            pipeline stall (only gates the bypass)       |
// |            cpsr_nxt, cpsr_wr  candidate CPSR value and write request      |
// |            status_out        bypassed flags for the condition checker     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module flag_next_sel
  import arm_pkg::*;
#(
  parameter int FLAG_W    = 4,
  parameter int BYPASS_EN = 1
) (
  input  logic [FLAG_W-1:0] cpsr_q,
  input  logic [FLAG_W-1:0] spsr_q,
  input  logic              exe_upd,
  input  logic [FLAG_W-1:0] exe_flags,
  input  logic              msr_we,
  input  logic [FLAG_W-1:0] msr_mask,
  input  logic [FLAG_W-1:0] msr_data,
  input  logic              legal_restore,
  input  logic              freeze,
  output logic [FLAG_W-1:0] cpsr_nxt,
  output logic              cpsr_wr,
  output logic [FLAG_W-1:0] status_out
);

  // Priority: exception return, then MSR, then the ALU result. The write
  // request is raw here; the top gates it with freeze.
  always_comb begin
    cpsr_nxt = cpsr_q;
    cpsr_wr  = 1'b0;
    if (legal_restore) begin
      cpsr_nxt = spsr_q;
      cpsr_wr  = 1'b1;
    end else if (msr_we) begin
      cpsr_nxt = (cpsr_q & ~msr_mask) | (msr_data & msr_mask);
      cpsr_wr  = 1'b1;
    end else if (exe_upd) begin
      cpsr_nxt = exe_flags;
      cpsr_wr  = 1'b1;
    end
  end

  // Only a plain ALU update is forwarded; restore/MSR results appear on
  // status_out one cycle later through cpsr_q.
  generate
    if (BYPASS_EN != 0) begin : g_bypass_on
      assign status_out = (exe_upd & ~freeze & ~msr_we & ~legal_restore)
                          ? exe_flags : cpsr_q;
    end else begin : g_bypass_off
      assign status_out = cpsr_q;
    end
  endgenerate

endmodule : flag_next_sel
`default_nettype wire

// File: rtl/status_reg_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : status_reg_unit                                                 |
// | Purpose  : Architectural NZCV flags (CPSR) plus one saved copy (SPSR)      |
// |            for exception entry/return, with a zero-bubble bypass of the    |
// |            EXE-stage flag result towards the ID-stage condition checker.   |
// | Ports    : clk, rst_n (sync, active low), freeze, flush                    |
// |            exe_valid, exe_s, exe_flags   EXE-stage flag update            |
// |            msr_we, msr_mask, msr_data    masked direct flag write         |
// |            save_req, restore_req         exception entry / return         |
// |            status_out  bypassed flags    cpsr_q, spsr_q  registered flags |
// |            in_exc      in EXC state      flags_wr  CPSR write pulse       |
// |            err_nest    sticky illegal save/restore indicator              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module status_reg_unit
  import arm_pkg::*;
#(
  parameter int              FLAG_W      = 4,
  parameter int              BYPASS_EN   = 1,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              exe_valid,
  input  logic              exe_s,
  input  logic [FLAG_W-1:0] exe_flags,
  input  logic              msr_we,
  input  logic [FLAG_W-1:0] msr_mask,
  input  logic [FLAG_W-1:0] msr_data,
  input  logic              save_req,
  input  logic              restore_req,
  output logic [FLAG_W-1:0] status_out,
  output logic [FLAG_W-1:0] cpsr_q,
  output logic [FLAG_W-1:0] spsr_q,
  output logic              in_exc,
  output logic              flags_wr,
  output logic              err_nest
);

  sr_state_e         state_q;
  sr_state_e         state_d;
  logic [FLAG_W-1:0] cpsr_d;
  logic [FLAG_W-1:0] spsr_d;
  logic              flags_wr_d;
  logic              err_nest_d;

  logic              exe_upd;
  logic              legal_save;
  logic              legal_restore;
  logic              illegal_req;
  logic [FLAG_W-1:0] cpsr_nxt;
  logic              cpsr_wr;

  assign exe_upd = exe_valid & exe_s & ~flush;

  // A simultaneous save and restore is never legal, whatever the state.
  assign legal_save    = save_req & ~restore_req & (state_q == ST_NORMAL);
  assign legal_restore = restore_req & ~save_req & (state_q == ST_EXC);
  assign illegal_req   = (save_req | restore_req) & ~legal_save & ~legal_restore;

  flag_next_sel #(
    .FLAG_W    (FLAG_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_flag_next_sel (
    .cpsr_q        (cpsr_q),
    .spsr_q        (spsr_q),
    .exe_upd       (exe_upd),
    .exe_flags     (exe_flags),
    .msr_we        (msr_we),
    .msr_mask      (msr_mask),
    .msr_data      (msr_data),
    .legal_restore (legal_restore),
    .freeze        (freeze),
    .cpsr_nxt      (cpsr_nxt),
    .cpsr_wr       (cpsr_wr),
    .status_out    (status_out)
  );

  // freeze blocks every state update, including the sticky error.
  always_comb begin
    state_d    = state_q;
    cpsr_d     = cpsr_q;
    spsr_d     = spsr_q;
    err_nest_d = err_nest;
    flags_wr_d = 1'b0;
    if (!freeze) begin
      if (legal_save) begin
        state_d = ST_EXC;
        spsr_d  = cpsr_q;  // pre-update value, even if CPSR is written now
      end
      if (legal_restore) begin
        state_d = ST_NORMAL;
      end
      if (illegal_req) begin
        err_nest_d = 1'b1;
      end
      if (cpsr_wr) begin
        cpsr_d     = cpsr_nxt;
        flags_wr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      cpsr_q   <= RESET_FLAGS;
      spsr_q   <= RESET_FLAGS;
      flags_wr <= 1'b0;
      err_nest <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpsr_q   <= cpsr_d;
      spsr_q   <= spsr_d;
      flags_wr <= flags_wr_d;
      err_nest <= err_nest_d;
    end
  end

  assign in_exc = (state_q == ST_EXC);

endmodule : status_reg_unit
`default_nettype wire

// File: tb/tb_status_reg_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_status_reg_unit                                              |
// | Purpose  : Directed, table-driven self-checking bench for status_reg_unit. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_status_reg_unit;

  logic       clk;
  logic       rst_n;
  logic       freeze;
  logic       flush;
  logic       exe_valid;
  logic       exe_s;
  logic [3:0] exe_flags;
  logic       msr_we;
  logic [3:0] msr_mask;
  logic [3:0] msr_data;
  logic       save_req;
  logic       restore_req;
  logic [3:0] status_out;
  logic [3:0] cpsr_q;
  logic [3:0] spsr_q;
  logic       in_exc;
  logic       flags_wr;
  logic       err_nest;

  int errors = 0;
  int checks = 0;

  status_reg_unit #(
    .FLAG_W      (4),
    .BYPASS_EN   (1),
    .RESET_FLAGS (4'b0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .flush       (flush),
    .exe_valid   (exe_valid),
    .exe_s       (exe_s),
    .exe_flags   (exe_flags),
    .msr_we      (msr_we),
    .msr_mask    (msr_mask),
    .msr_data    (msr_data),
    .save_req    (save_req),
    .restore_req (restore_req),
    .status_out  (status_out),
    .cpsr_q      (cpsr_q),
    .spsr_q      (spsr_q),
    .in_exc      (in_exc),
    .flags_wr    (flags_wr),
    .err_nest    (err_nest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs for one clock cycle; st is status_out before the edge,
  // the rest are the registered outputs after the edge.
  typedef struct {
    logic       rst_n, frz, fl, v, s;
    logic [3:0] ef;
    logic       mwe;
    logic [3:0] mm, md;
    logic       sv, rs;
    logic       chk_st;
    logic [3:0] st, cpsr, spsr;
    logic       exc, fw, err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic frz, input logic fl,
                         input logic v, input logic s, input logic [3:0] ef,
                         input logic mwe, input logic [3:0] mm, input logic [3:0] md,
                         input logic sv, input logic rs, input logic chk_st,
                         input logic [3:0] st, input logic [3:0] cpsr,
                         input logic [3:0] spsr, input logic exc,
                         input logic fw, input logic err);
    vec_t t;
    t.rst_n = r;  t.frz = frz; t.fl = fl; t.v = v; t.s = s; t.ef = ef;
    t.mwe = mwe;  t.mm = mm;   t.md = md; t.sv = sv; t.rs = rs;
    t.chk_st = chk_st; t.st = st; t.cpsr = cpsr; t.spsr = spsr;
    t.exc = exc; t.fw = fw; t.err = err;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic frz, input logic fl,
                       input logic v, input logic s, input logic [3:0] ef,
                       input logic mwe, input logic [3:0] mm, input logic [3:0] md,
                       input logic sv, input logic rs);
    rst_n = r; freeze = frz; flush = fl; exe_valid = v; exe_s = s;
    exe_flags = ef; msr_we = mwe; msr_mask = mm; msr_data = md;
    save_req = sv; restore_req = rs;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    //       rst frz fl  v   s   ef       mwe mm       md       sv  rs  cst st       cpsr     spsr     exc fw  err
    add_vec(0,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 0,  0,  0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  0); // reset
    add_vec(1,  0,  0,  1,  1,  4'b0100, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b0100, 4'b0100, 4'b0000, 0,  1,  0); // bypass + write
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b0100, 4'b0100, 4'b0000, 0,  0,  0); // pulse ends
    add_vec(1,  0,  1,  1,  1,  4'b1111, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b0100, 4'b0100, 4'b0000, 0,  0,  0); // flush kills
    add_vec(1,  0,  0,  1,  1,  4'b1010, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b1010, 4'b1010, 4'b0000, 0,  1,  0);
    add_vec(1,  0,  0,  1,  1,  4'b0000, 1,  4'b0011, 4'b0101, 0,  0,  1,  4'b1010, 4'b1001, 4'b0000, 0,  1,  0); // MSR wins
    add_vec(1,  0,  0,  1,  1,  4'b0110, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b0110, 4'b0110, 4'b0000, 0,  1,  0);
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b0110, 4'b0110, 4'b0110, 1,  0,  0); // save
    add_vec(1,  0,  0,  1,  1,  4'b1000, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b1000, 4'b1000, 4'b0110, 1,  1,  0);
    add_vec(1,  0,  0,  1,  1,  4'b1111, 0,  4'b0000, 4'b0000, 0,  1,  1,  4'b1000, 4'b0110, 4'b0110, 0,  1,  0); // restore beats exe
    add_vec(1,  0,  0,  1,  1,  4'b0011, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b0011, 4'b0011, 4'b0110, 0,  1,  0);
    add_vec(1,  1,  0,  1,  1,  4'b1111, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b0011, 4'b0011, 4'b0110, 0,  0,  0); // freeze x3
    add_vec(1,  1,  0,  1,  1,  4'b1111, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b0011, 4'b0011, 4'b0110, 0,  0,  0);
    add_vec(1,  1,  0,  1,  1,  4'b1111, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b0011, 4'b0011, 4'b0110, 0,  0,  0);
    add_vec(1,  0,  0,  1,  1,  4'b0101, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b0101, 4'b0101, 4'b0011, 1,  1,  0); // save + exe
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 1,  1,  1,  4'b0101, 4'b0101, 4'b0011, 1,  0,  1); // both in EXC
    add_vec(0,  1,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 0,  0,  0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  0); // reset in EXC, frozen
    add_vec(1,  0,  0,  1,  1,  4'b1100, 0,  4'b0000, 4'b0000, 0,  0,  1,  4'b1100, 4'b1100, 4'b0000, 0,  1,  0);
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 0,  1,  1,  4'b1100, 4'b1100, 4'b0000, 0,  0,  1); // restore in NORMAL
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 1,  1,  1,  4'b1100, 4'b1100, 4'b0000, 0,  0,  1); // both in NORMAL
    add_vec(1,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 1,  0,  1,  4'b1100, 4'b1100, 4'b1100, 1,  0,  1);
    add_vec(1,  0,  0,  0,  0,  4'b0000, 1,  4'b1111, 4'b0001, 1,  0,  1,  4'b1100, 4'b0001, 4'b1100, 1,  1,  1); // save in EXC + MSR
    add_vec(0,  0,  0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 0,  0,  0,  4'b0000, 4'b0000, 4'b0000, 0,  0,  0); // reset clears err

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].frz, vecs[i].fl, vecs[i].v, vecs[i].s,
            vecs[i].ef, vecs[i].mwe, vecs[i].mm, vecs[i].md, vecs[i].sv, vecs[i].rs);
      #1;
      if (vecs[i].chk_st) chk("status_out", i, status_out, vecs[i].st);
      @(posedge clk);
      #1;
      chk("cpsr_q",   i, cpsr_q,         vecs[i].cpsr);
      chk("spsr_q",   i, spsr_q,         vecs[i].spsr);
      chk("in_exc",   i, {3'b000, in_exc},   {3'b000, vecs[i].exc});
      chk("flags_wr", i, {3'b000, flags_wr}, {3'b000, vecs[i].fw});
      chk("err_nest", i, {3'b000, err_nest}, {3'b000, vecs[i].err});
    end

    // Back-to-back identical ALU updates: flags_wr stays high each cycle.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("seq_status", 100, status_out, 4'b0111);
    @(posedge clk); #1;
    chk("seq_cpsr", 100, cpsr_q, 4'b0111);
    chk("seq_fw", 100, {3'b000, flags_wr}, 4'b0001);
    @(negedge clk);
    #1;
    chk("seq_status", 101, status_out, 4'b0111);
    @(posedge clk); #1;
    chk("seq_fw", 101, {3'b000, flags_wr}, 4'b0001);

    // MSR with an all-zero mask is still a write: value kept, pulse raised.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("seq_cpsr", 102, cpsr_q, 4'b0111);
    chk("seq_fw", 102, {3'b000, flags_wr}, 4'b0001);

    // Idle: pulse drops.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("seq_fw", 103, {3'b000, flags_wr}, 4'b0000);
    chk("seq_cpsr", 103, cpsr_q, 4'b0111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_status_reg_unit
`default_nettype wire
